// File: rtl/axis_record_framer.sv
// Record-path framer: cuts a continuous AXI4-Stream sample stream into DMA packets of
// packet_len beats, zero-padding an open packet when recording is disabled.
module axis_record_framer #(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  axis_aclk,
  input  logic                  axis_aresetn,
  input  logic                  enable,
  input  logic [LEN_WIDTH-1:0]  packet_len,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [31:0]           packet_count,
  output logic [31:0]           drop_count,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, STREAM, PAD} state_t;

  state_t                state_reg, state_next;
  logic [LEN_WIDTH-1:0]  len_reg, len_next;
  logic [LEN_WIDTH-1:0]  beat_cnt_reg, beat_cnt_next;
  logic                  tready_reg, tready_next;
  logic [1:0]            count_reg, count_next;
  logic [DATA_WIDTH-1:0] head_data_reg, tail_data_reg;
  logic                  head_last_reg, tail_last_reg;
  logic [31:0]           packet_count_reg, drop_count_reg;

  logic                  pop, space, accept, at_last, wr_tail;
  logic                  push, push_last;
  logic [DATA_WIDTH-1:0] push_data;
  logic [LEN_WIDTH-1:0]  len_eff;

  assign len_eff = (packet_len == '0) ? LEN_WIDTH'(1) : packet_len;
  assign pop     = (count_reg != 2'd0) && m_axis_tready;
  assign space   = (count_reg != 2'd2) || pop;
  assign accept  = s_axis_tvalid && tready_reg;
  assign at_last = (beat_cnt_reg == len_reg - LEN_WIDTH'(1));
  // Write slot is the one left free after this cycle's pop.
  assign wr_tail = (count_reg == 2'd2) || ((count_reg == 2'd1) && !pop);

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_reg    <= IDLE;
      len_reg      <= LEN_WIDTH'(1);
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (enable) begin
          state_next    = STREAM;
          len_next      = len_eff;
          beat_cnt_next = '0;
        end
      end
      STREAM: begin
        if (accept) begin
          if (at_last) begin
            beat_cnt_next = '0;
            if (enable) len_next = len_eff;
            else        state_next = IDLE;
          end else begin
            beat_cnt_next = beat_cnt_reg + LEN_WIDTH'(1);
          end
        end else if (!enable) begin
          state_next = (beat_cnt_reg == '0) ? IDLE : PAD;
        end
      end
      PAD: begin
        if (space) begin
          if (at_last) begin
            beat_cnt_next = '0;
            state_next    = IDLE;
          end else begin
            beat_cnt_next = beat_cnt_reg + LEN_WIDTH'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    push_last = at_last;
    case (state_reg)
      STREAM: begin
        push      = accept;
        push_data = s_axis_tdata;
      end
      PAD:     push = space;
      default: push = 1'b0;
    endcase
  end

  assign count_next = count_reg + {1'b0, push} - {1'b0, pop};
  // Ready looks only at post-edge occupancy, so it never depends on m_axis_tready.
  assign tready_next = (state_next == IDLE) ||
                       ((state_next == STREAM) && (count_next != 2'd2));

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      count_reg     <= 2'd0;
      tready_reg    <= 1'b0;
      head_data_reg <= '0;
      tail_data_reg <= '0;
      head_last_reg <= 1'b0;
      tail_last_reg <= 1'b0;
    end else begin
      count_reg  <= count_next;
      tready_reg <= tready_next;
      if (pop) begin
        head_data_reg <= tail_data_reg;
        head_last_reg <= tail_last_reg;
      end
      if (push) begin
        if (wr_tail) begin
          tail_data_reg <= push_data;
          tail_last_reg <= push_last;
        end else begin
          head_data_reg <= push_data;
          head_last_reg <= push_last;
        end
      end
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      packet_count_reg <= '0;
      drop_count_reg   <= '0;
    end else begin
      if (pop && head_last_reg)
        packet_count_reg <= packet_count_reg + 32'd1;
      if ((state_reg == IDLE) && accept && (drop_count_reg != 32'hFFFF_FFFF))
        drop_count_reg <= drop_count_reg + 32'd1;
    end
  end

  assign s_axis_tready = tready_reg;
  assign m_axis_tvalid = (count_reg != 2'd0);
  assign m_axis_tdata  = head_data_reg;
  assign m_axis_tlast  = head_last_reg;
  assign packet_count  = packet_count_reg;
  assign drop_count    = drop_count_reg;
  assign busy          = (state_reg != IDLE) || (count_reg != 2'd0);

endmodule

// File: tb/tb_axis_record_framer.sv
// Directed bench for axis_record_framer: expected beats are queued as samples are
// accepted (or pads are due) and compared as the DMA side takes them.
module tb_axis_record_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] packet_len;
  logic        s_tvalid;
  logic        s_tready;
  logic [63:0] s_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [63:0] m_tdata;
  logic        m_tlast;
  logic [31:0] packet_count;
  logic [31:0] drop_count;
  logic        busy;

  always #5 clk = ~clk;

  axis_record_framer #(.DATA_WIDTH(64), .LEN_WIDTH(16)) dut (
    .axis_aclk     (clk),
    .axis_aresetn  (rst_n),
    .enable        (enable),
    .packet_len    (packet_len),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .packet_count  (packet_count),
    .drop_count    (drop_count),
    .busy          (busy)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [64:0] sb[$];
  logic        bp_mode = 1'b0;
  int          cyc = 0;
  int          first_pop_cyc = -1;
  int          last_pop_cyc = -1;
  int          pos = 0;
  int          cur_len = 1;
  logic        prev_stall = 1'b0;
  logic [64:0] prev_beat = '0;
  logic [64:0] exp_beat;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int eff_len(input logic [15:0] l);
    return (l == 16'd0) ? 1 : int'(l);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // DMA-side monitor: stall stability, full-buffer ready, scoreboard pop.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bp_mode && sb.size() >= 2)
        check("tready_when_full", {64'd0, s_tready}, 65'd0);
      if (prev_stall)
        check("stall_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, prev_beat});
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 65'(sb.size()), 65'd1);
        end else begin
          exp_beat = sb.pop_front();
          check("beat", {m_tlast, m_tdata}, exp_beat);
        end
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = {m_tlast, m_tdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (bp_mode) m_tready = ~m_tready;
  endtask

  // Offer one sample until accepted; forwarded samples are queued with the model's last flag.
  task automatic send(input logic [63:0] d, input logic fwd);
    logic acc;
    logic lst;
    acc = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      acc = s_tready;
      if (acc && fwd) begin
        #1;
        lst = (pos + 1 == cur_len);
        sb.push_back({lst, d});
        if (lst) begin
          pos = 0;
          cur_len = eff_len(packet_len);
        end else begin
          pos++;
        end
      end
      tick();
      if (acc) break;
    end
    s_tvalid = 1'b0;
    if (!acc) check("accept_timeout", {64'd0, acc}, 65'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 500 && sb.size() != 0; n++) tick();
    check("drain", 65'(sb.size()), 65'd0);
    tick();
    tick();
  endtask

  task automatic start_rec(input logic [15:0] len);
    packet_len = len;
    enable = 1'b1;
    tick();
    cur_len = eff_len(len);
    pos = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; enable = 1'b0; packet_len = 16'd4;
    s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst_tready", {64'd0, s_tready}, 65'd0);
    check("rst_tvalid", {64'd0, m_tvalid}, 65'd0);
    check("rst_tdata_tlast", {m_tlast, m_tdata}, 65'd0);
    check("rst_counts", {1'b0, packet_count, drop_count}, 65'd0);
    check("rst_busy", {64'd0, busy}, 65'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_tready", {64'd0, s_tready}, 65'd1);

    // Steady stream: 12 samples, packets of 4, no bubbles
    start_rec(16'd4);
    first_pop_cyc = -1;
    for (int i = 1; i <= 12; i++) send(64'(i), 1'b1);
    drain();
    enable = 1'b0;
    tick();
    check("steady_packets", {33'd0, packet_count}, 65'd3);
    check("no_bubble", 65'(last_pop_cyc - first_pop_cyc), 65'd11);

    // Backpressure: sink toggles, source gaps random
    start_rec(16'd3);
    bp_mode = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send({32'hB0B0_0000 + 32'(i), $urandom}, 1'b1);
      if ($urandom_range(0, 1) == 1) tick();
    end
    drain();
    bp_mode = 1'b0;
    m_tready = 1'b1;
    enable = 1'b0;
    tick();
    check("bp_packets", {33'd0, packet_count}, 65'd7);

    // Disable after 3 of 8 samples: five zero pads, last one carries tlast
    start_rec(16'd8);
    for (int i = 0; i < 3; i++) send(64'hA1 + 64'(i), 1'b1);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) sb.push_back({(i == 4), 64'd0});
    drain();
    check("pad_idle_busy", {64'd0, busy}, 65'd0);
    check("pad_packets", {33'd0, packet_count}, 65'd8);

    // Idle drop, then length 0 acts as single-beat packets
    for (int i = 0; i < 10; i++) send(64'hDEAD + 64'(i), 1'b0);
    check("drop_count", {33'd0, drop_count}, 65'd10);
    check("drop_no_output", {64'd0, m_tvalid}, 65'd0);
    start_rec(16'd0);
    send(64'h51, 1'b1);
    send(64'h52, 1'b1);
    drain();
    enable = 1'b0;
    tick();
    check("len0_packets", {33'd0, packet_count}, 65'd10);

    // Length change mid-packet takes effect at the next packet only
    start_rec(16'd2);
    send(64'hC1, 1'b1);
    packet_len = 16'd5;
    for (int i = 2; i <= 7; i++) send(64'hC0 + 64'(i), 1'b1);
    drain();
    enable = 1'b0;
    tick();
    check("len_change_packets", {33'd0, packet_count}, 65'd12);

    // Async reset with the buffer full
    m_tready = 1'b0;
    start_rec(16'd8);
    send(64'hE1, 1'b1);
    send(64'hE2, 1'b1);
    check("full_tready", {64'd0, s_tready}, 65'd0);
    check("full_head", {m_tvalid, m_tdata}, {1'b1, 64'hE1});
    #2 rst_n = 1'b0;
    #1;
    check("arst_tvalid", {64'd0, m_tvalid}, 65'd0);
    check("arst_busy", {64'd0, busy}, 65'd0);
    check("arst_counts", {1'b0, packet_count, drop_count}, 65'd0);
    check("arst_tready", {64'd0, s_tready}, 65'd0);
    sb.delete();
    enable = 1'b0;
    m_tready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_arst_tready", {64'd0, s_tready}, 65'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
